serial_subtraction: RTL and testbench

- Bit-serial unsigned subtractor for the calculator datapath; it is the inverse operation of the combinational `addition` block.
- Takes two `n`-bit unsigned operands on a `start` pulse and computes `a - b` one bit per clock through a single borrow cell.
- Returns the result in sign-magnitude form: `result` holds the magnitude and `negative` the sign, ready for the display path.
- Trades latency for one full-subtractor cell instead of an `n`-bit borrow chain.

---
 rtl/calc_pkg.sv | 15 +
 rtl/full_subtractor.sv | 20 ++
 rtl/serial_subtraction.sv | 142 ++++++++++++++
 tb/tb_serial_subtraction.sv | 139 +++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: definitions shared by the calculator datapath blocks.
//   CALC_WIDTH  - default operand/result width (shared with `addition`)
//   sub_state_t - control states of the bit-serial subtractor
package calc_pkg;

  localparam int CALC_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: 1-bit borrow cell, purely combinational.
// Ports:
//   a    in  1  minuend bit
//   b    in  1  subtrahend bit
//   bin  in  1  borrow in
//   d    out 1  difference bit
//   bout out 1  borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtraction.sv
// serial_subtraction: bit-serial unsigned subtractor, a - b, one bit per clock
// through a single full_subtractor cell. The result is returned in
// sign-magnitude form.
// Ports:
//   clk      in  1  clock, rising edge
//   rst_n    in  1  asynchronous active-low reset
//   start    in  1  begin request, sampled only in IDLE
//   a        in  n  minuend, captured on accepted start
//   b        in  n  subtrahend, captured on accepted start
//   busy     out 1  high in SUB, NEG and DONE
//   done     out 1  one-cycle pulse in DONE
//   result   out n  |a - b|, registered
//   negative out 1  a < b, registered
module serial_subtraction
  import calc_pkg::*;
#(
  parameter int n = CALC_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] result,
  output logic         negative
);

  localparam int CW = $clog2(n + 1);
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  sub_state_t state_reg, state_next;

  logic [n-1:0]  a_reg, b_reg, diff_reg;
  logic          bw_reg, seen_reg;
  logic [CW-1:0] cnt_reg;
  logic [n-1:0]  result_reg;
  logic          negative_reg;

  logic          d_bit, bout_bit, neg_bit, in_bit, last_bit;
  logic [n:0]    shift_tmp;
  logic [n-1:0]  diff_shift;

  full_subtractor u_fs (
    .a   (a_reg[0]),
    .b   (b_reg[0]),
    .bin (bw_reg),
    .d   (d_bit),
    .bout(bout_bit)
  );

  // Counter is shared by SUB and NEG; both phases last exactly n cycles.
  assign last_bit = (cnt_reg == LAST);

  // Serial two's complement: copy bits up to and including the first 1,
  // invert every bit after it.
  assign neg_bit = diff_reg[0] ^ seen_reg;

  // The difference register is filled MSB-first during SUB and rotated
  // during NEG; either way the new bit enters at the top. Built through an
  // n+1 wide temporary so the slice stays legal for n = 1.
  assign in_bit     = (state_reg == NEG) ? neg_bit : d_bit;
  assign shift_tmp  = {in_bit, diff_reg};
  assign diff_shift = shift_tmp[n:1];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = SUB;
      SUB:  if (last_bit) state_next = bout_bit ? NEG : DONE;
      NEG:  if (last_bit) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs depend only on registers.
  always_comb begin
    busy     = (state_reg != IDLE);
    done     = (state_reg == DONE);
    result   = result_reg;
    negative = negative_reg;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg        <= '0;
      b_reg        <= '0;
      diff_reg     <= '0;
      bw_reg       <= 1'b0;
      seen_reg     <= 1'b0;
      cnt_reg      <= '0;
      result_reg   <= '0;
      negative_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg    <= a;
            b_reg    <= b;
            diff_reg <= '0;
            bw_reg   <= 1'b0;
            cnt_reg  <= '0;
          end
        end
        SUB: begin
          a_reg    <= a_reg >> 1;
          b_reg    <= b_reg >> 1;
          bw_reg   <= bout_bit;
          diff_reg <= diff_shift;
          seen_reg <= 1'b0;
          cnt_reg  <= last_bit ? '0 : cnt_reg + CW'(1);
          // No final borrow: the raw difference is already the magnitude.
          if (last_bit && !bout_bit) begin
            result_reg   <= diff_shift;
            negative_reg <= 1'b0;
          end
        end
        NEG: begin
          diff_reg <= diff_shift;
          seen_reg <= seen_reg | diff_reg[0];
          cnt_reg  <= cnt_reg + CW'(1);
          if (last_bit) begin
            result_reg   <= diff_shift;
            negative_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtraction.sv
// tb_serial_subtraction: directed checks of serial_subtraction with n = 6.
module tb_serial_subtraction;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] a;
  logic [5:0] b;
  logic       busy;
  logic       done;
  logic [5:0] result;
  logic       negative;

  int n_checks = 0;
  int n_errors = 0;

  serial_subtraction #(.n(6)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .negative(negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one operation starting at a negedge in IDLE. Optionally pulses a
  // second start (a=1,b=60) so that it is sampled at edge E<inject_at>.
  // Returns at the negedge of the first IDLE cycle after DONE.
  task automatic run_op(input logic [5:0] op_a, input logic [5:0] op_b,
                        input logic [5:0] exp_res, input logic exp_neg,
                        input int exp_lat, input int inject_at);
    int  k;
    int  lat;
    bit  busy_ok;
    start = 1'b1;
    a     = op_a;
    b     = op_b;
    @(posedge clk);  // E0
    @(negedge clk);
    start   = 1'b0;
    k       = 0;
    lat     = -1;
    busy_ok = 1'b1;
    while (k < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (k == inject_at - 1) begin
        start = 1'b1;
        a     = 6'd1;
        b     = 6'd60;
      end else if (k == inject_at) begin
        start = 1'b0;
      end
      @(posedge clk);
      k++;
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    check("done_latency", lat, exp_lat);
    check("busy_during", busy_ok, 1);
    check("busy_at_done", busy, 1);
    check("result", result, exp_res);
    check("negative", negative, exp_neg);
    @(posedge clk);
    @(negedge clk);
    check("done_cleared", done, 0);
    check("busy_cleared", busy, 0);
    check("result_held", result, exp_res);
    $display("op a=%0d b=%0d -> result=%0d negative=%0d latency=%0d", op_a, op_b, result, negative, lat);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_negative", negative, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(6'd45, 6'd17, 6'd28, 1'b0, 6, 0);
    run_op(6'd17, 6'd45, 6'd28, 1'b1, 12, 0);
    run_op(6'd0,  6'd63, 6'd63, 1'b1, 12, 0);
    run_op(6'd63, 6'd0,  6'd63, 1'b0, 6, 0);
    run_op(6'd33, 6'd33, 6'd0,  1'b0, 6, 0);

    // Second start sampled at E3 while in SUB must be ignored.
    run_op(6'd10, 6'd3,  6'd7,  1'b0, 6, 3);
    // Start in the first IDLE cycle afterwards is accepted.
    run_op(6'd1,  6'd60, 6'd59, 1'b1, 12, 0);

    // Reset in the middle of NEG.
    start = 1'b1;
    a     = 6'd17;
    b     = 6'd45;
    @(posedge clk);  // E0
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);  // E8, inside NEG
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_negative", negative, 0);
    $display("reset asserted mid-NEG: busy=%0d done=%0d result=%0d negative=%0d", busy, done, result, negative);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(6'd5, 6'd9, 6'd4, 1'b1, 12, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
